dmem_arbiter: RTL

Two-requester round-robin arbiter that shares the single data memory between requester 0 (CPU load/store path) and requester 1 (loader/debug/DMA master).
- Grants at most one access per cycle and drives the memory address, write-data and write-enable.
- Registers read data back to the granted requester one cycle later.
- Supports bounded lock bursts and flags out-of-range word addresses.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_rr_pick.sv | 16 +
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state encoding and port indices for the data memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-way round-robin pick
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  // On a tie the port that was not granted last wins.
  assign gnt_valid = req0 | req1;
  assign gnt_idx   = (req0 & req1) ? ~last : (req1 ? P1 : P0);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data memory arbiter with bounded lock bursts
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t     state;
  logic           last;
  logic [CW-1:0]  burst_cnt;

  logic           pick_valid;
  logic           pick_idx;
  logic           hold;
  logic           gnt_valid;
  logic           gnt_idx;
  logic [31:0]    sel_a;
  logic [31:0]    sel_wd;
  logic           sel_we;
  logic           sel_lock;
  logic           in_range;
  logic [CW-1:0]  next_cnt;
  logic           extend_lock;

  dmem_rr_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // A lock only holds while its owner keeps requesting; otherwise re-arbitrate this same cycle.
  assign hold = ((state == LOCK0) && req0) || ((state == LOCK1) && req1);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = P0;
    if (!reset) begin
      if ((state == LOCK0) && req0) begin
        gnt_valid = 1'b1;
        gnt_idx   = P0;
      end else if ((state == LOCK1) && req1) begin
        gnt_valid = 1'b1;
        gnt_idx   = P1;
      end else begin
        gnt_valid = pick_valid;
        gnt_idx   = pick_idx;
      end
    end
  end

  assign sel_a    = (gnt_idx == P1) ? a1    : a0;
  assign sel_wd   = (gnt_idx == P1) ? wd1   : wd0;
  assign sel_we   = (gnt_idx == P1) ? we1   : we0;
  assign sel_lock = (gnt_idx == P1) ? lock1 : lock0;
  assign in_range = sel_a[31:2] < 30'(DEPTH);

  assign gnt0   = gnt_valid & (gnt_idx == P0);
  assign gnt1   = gnt_valid & (gnt_idx == P1);
  assign mem_a  = gnt_valid ? sel_a  : 32'd0;
  assign mem_wd = gnt_valid ? sel_wd : 32'd0;
  assign mem_we = gnt_valid & sel_we & in_range;

  // Count restarts from zero whenever the grant is not a continuation of a held lock.
  assign next_cnt    = (hold ? burst_cnt : CW'(0)) + CW'(1);
  assign extend_lock = sel_lock && (32'(next_cnt) < 32'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= P1;
      burst_cnt <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= 32'd0;
      rdata1    <= 32'd0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      if (gnt_valid) begin
        last <= gnt_idx;
        if (extend_lock) begin
          state     <= (gnt_idx == P1) ? LOCK1 : LOCK0;
          burst_cnt <= next_cnt;
        end else begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
        if (gnt_idx == P0) begin
          err0 <= ~in_range;
          if (!sel_we) begin
            rvalid0 <= 1'b1;
            rdata0  <= in_range ? mem_rd : 32'd0;
          end
        end else begin
          err1 <= ~in_range;
          if (!sel_we) begin
            rvalid1 <= 1'b1;
            rdata1  <= in_range ? mem_rd : 32'd0;
          end
        end
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

endmodule
